inst_fetch_unit: RTL and testbench

//  Fetch-stage controller on the consumer side of the program counter: reads PC_current, drives PC_next back.

---
 rtl/mips16_pkg.sv | 24 ++
 rtl/fetch_skid_buf.sv | 54 +++++
 rtl/inst_fetch_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips16_pkg.sv
// -----------------------------------------------------------------------------
// mips16_pkg
//   Shared constants and types for the MIPS16 fetch front end.
//   - PC_SIZE   : word-address width (PC counts 16-bit words)
//   - inst_SIZE : instruction width in bits
//   - fetch_state_t : fetch FSM states
//       S_IDLE  no imem request outstanding
//       S_REQ   request outstanding, result will be kept
//       S_DROP  request outstanding, result will be discarded (post-redirect)
//       S_FULL  skid entry holds an instruction, no request outstanding
// -----------------------------------------------------------------------------
package mips16_pkg;

  localparam int PC_SIZE   = 13;
  localparam int inst_SIZE = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2,
    S_FULL = 2'd3
  } fetch_state_t;

endpackage : mips16_pkg

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
//   One-entry {inst, pc} holding buffer used when an imem result arrives while
//   decode is stalled and the IF/ID register is occupied.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous, active-low reset
//   load      in   capture in_inst/in_pc, mark full
//   drain     in   entry consumed this edge, mark empty
//   clear     in   discard entry (redirect); wins over load/drain
//   in_inst   in   instruction to capture
//   in_pc     in   address of in_inst
//   full      out  entry valid
//   out_inst  out  held instruction
//   out_pc    out  held address
// -----------------------------------------------------------------------------
module fetch_skid_buf
  import mips16_pkg::*;
#(
  parameter int inst_W = mips16_pkg::inst_SIZE,
  parameter int PC_W   = mips16_pkg::PC_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drain,
  input  logic              clear,
  input  logic [inst_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  output logic              full,
  output logic [inst_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc
);

  // NOTE: the data fields are reset along with the full flag. A single entry is
  // cheap to reset, and it keeps out_inst/out_pc free of X after reset even
  // though they are only looked at while full=1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full     <= 1'b0;
      out_inst <= '0;
      out_pc   <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full     <= 1'b1;
      out_inst <= in_inst;
      out_pc   <= in_pc;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule : fetch_skid_buf

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//   Fetch-stage controller. Reads the registered PC, returns the next PC,
//   issues word reads to a variable-latency instruction memory over req/ack,
//   and loads the IF/ID register honouring decode stalls and branch/jump
//   redirects, with one skid entry for results that arrive during a stall.
//
//   Optional feature: define FETCH_PERF_CNT_EN to build a saturating 16-bit
//   counter of imem wait cycles on perf_wait; otherwise perf_wait is 0.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst         in   asynchronous, active-low reset
//   PC_current  in   registered PC from program_counter
//   PC_next     out  next PC to program_counter (combinational)
//   imem_req    out  read request (registered)
//   imem_addr   out  read address (registered, stable while imem_req=1)
//   imem_ack    in   read data valid this cycle
//   imem_rdata  in   read data
//   br_taken    in   EX branch resolved taken (priority over jmp)
//   br_target   in   branch target
//   jmp         in   ID jump
//   jmp_target  in   jump target
//   id_stall    in   decode cannot accept IF/ID this cycle
//   if_valid    out  IF/ID holds a valid instruction
//   if_inst     out  IF/ID instruction
//   if_pc       out  address of if_inst
//   perf_wait   out  imem wait-cycle counter
// -----------------------------------------------------------------------------
module inst_fetch_unit
  import mips16_pkg::*;
#(
  parameter int inst_W = mips16_pkg::inst_SIZE,
  parameter int PC_W   = mips16_pkg::PC_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   PC_current,
  output logic [PC_W-1:0]   PC_next,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [inst_W-1:0] imem_rdata,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  input  logic              jmp,
  input  logic [PC_W-1:0]   jmp_target,
  input  logic              id_stall,
  output logic              if_valid,
  output logic [inst_W-1:0] if_inst,
  output logic [PC_W-1:0]   if_pc,
  output logic [15:0]       perf_wait
);

  fetch_state_t state, state_next;

  logic              slot_free;
  logic              redirect;
  logic              launch;      // new request issued at this edge
  logic              req_hold;    // outstanding request not yet acked
  logic              load_mem;    // imem result goes straight to IF/ID
  logic              load_skid;   // skid entry drains to IF/ID
  logic              skid_load;   // imem result parked in the skid entry
  logic              skid_full;
  logic [inst_W-1:0] skid_inst;
  logic [PC_W-1:0]   skid_pc;
  logic [PC_W-1:0]   pc_plus1;

  assign slot_free = !if_valid || !id_stall;
  assign redirect  = br_taken || jmp;
  // Wraps naturally at 2^PC_W.
  assign pc_plus1  = PC_current + {{(PC_W-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and control decode
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path through
  // the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    req_hold   = 1'b0;
    load_mem   = 1'b0;
    load_skid  = 1'b0;
    skid_load  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (!redirect) begin
          launch     = 1'b1;
          state_next = S_REQ;
        end
      end

      S_REQ: begin
        if (redirect) begin
          // An acked result is simply dropped; an unacked one must still be
          // waited out, but its data will be thrown away.
          if (imem_ack) begin
            state_next = S_IDLE;
          end else begin
            req_hold   = 1'b1;
            state_next = S_DROP;
          end
        end else if (imem_ack) begin
          if (slot_free) begin
            load_mem = 1'b1;
            launch   = 1'b1;
          end else begin
            skid_load  = 1'b1;
            state_next = S_FULL;
          end
        end else begin
          req_hold = 1'b1;
        end
      end

      S_DROP: begin
        if (redirect) begin
          if (imem_ack) state_next = S_IDLE;
          else          req_hold   = 1'b1;
        end else if (imem_ack) begin
          launch     = 1'b1;
          state_next = S_REQ;
        end else begin
          req_hold = 1'b1;
        end
      end

      S_FULL: begin
        if (redirect) begin
          state_next = S_IDLE;
        end else if (slot_free && skid_full) begin
          // Skid drains into IF/ID and the next fetch goes out on the same edge.
          load_skid  = 1'b1;
          launch     = 1'b1;
          state_next = S_REQ;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // PC_next mux: redirect > sequential launch > hold
  // ---------------------------------------------------------------------------
  always_comb begin
    if (br_taken)    PC_next = br_target;
    else if (jmp)    PC_next = jmp_target;
    else if (launch) PC_next = pc_plus1;
    else             PC_next = PC_current;
  end

  // ---------------------------------------------------------------------------
  // imem request/address registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      imem_req <= launch || req_hold;
      if (launch) imem_addr <= PC_current;
    end
  end

  // ---------------------------------------------------------------------------
  // IF/ID register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_valid <= 1'b0;
      if_inst  <= '0;
      if_pc    <= '0;
    end else if (redirect) begin
      // Flush even when decode is stalled: the held instruction is wrong-path.
      if_valid <= 1'b0;
    end else if (load_mem) begin
      if_valid <= 1'b1;
      if_inst  <= imem_rdata;
      if_pc    <= imem_addr;
    end else if (load_skid) begin
      if_valid <= 1'b1;
      if_inst  <= skid_inst;
      if_pc    <= skid_pc;
    end else if (slot_free) begin
      if_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Skid entry
  // ---------------------------------------------------------------------------
  fetch_skid_buf #(
    .inst_W (inst_W),
    .PC_W   (PC_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .drain    (load_skid),
    .clear    (redirect),
    .in_inst  (imem_rdata),
    .in_pc    (imem_addr),
    .full     (skid_full),
    .out_inst (skid_inst),
    .out_pc   (skid_pc)
  );

  // ---------------------------------------------------------------------------
  // Optional imem wait-cycle counter
  // ---------------------------------------------------------------------------
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cnt <= 16'h0000;
    end else if (imem_req && !imem_ack && (perf_cnt != 16'hFFFF)) begin
      perf_cnt <= perf_cnt + 16'h0001;
    end
  end

  assign perf_wait = perf_cnt;
`else
  assign perf_wait = 16'h0000;
`endif

endmodule : inst_fetch_unit

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
//   Directed bench for inst_fetch_unit. Contains a program_counter stand-in
//   (pc <= PC_next each edge, reset to pc_init) and an imem model that acks
//   after imem_wait cycles with data {3'b101, addr}.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

  localparam int PW = 13;
  localparam int IW = 16;

  logic          clk;
  logic          rst;
  logic [PW-1:0] pc;
  logic [PW-1:0] PC_next;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic          br_taken;
  logic [PW-1:0] br_target;
  logic          jmp;
  logic [PW-1:0] jmp_target;
  logic          id_stall;
  logic          if_valid;
  logic [IW-1:0] if_inst;
  logic [PW-1:0] if_pc;
  logic [15:0]   perf_wait;

  logic [PW-1:0] pc_init;
  int            imem_wait;
  int            wait_cnt;
  int            errors;
  int            checks;

  inst_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .PC_current (pc),
    .PC_next    (PC_next),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .id_stall   (id_stall),
    .if_valid   (if_valid),
    .if_inst    (if_inst),
    .if_pc      (if_pc),
    .perf_wait  (perf_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // program_counter stand-in
  always @(posedge clk or negedge rst) begin
    if (!rst) pc <= pc_init;
    else      pc <= PC_next;
  end

  // imem model: ack after imem_wait wait cycles
  always @(posedge clk or negedge rst) begin
    if (!rst)                       wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                            wait_cnt <= 0;
  end

  assign imem_ack   = imem_req && (wait_cnt >= imem_wait);
  assign imem_rdata = {3'b101, imem_addr};

  function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
    return {3'b101, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds reset across one edge, then releases it; returns in the first
  // cycle after reset (cycle 0).
  task automatic do_reset(input logic [PW-1:0] p0, input int w, input bit chk);
    pc_init    = p0;
    imem_wait  = w;
    br_taken   = 1'b0;
    jmp        = 1'b0;
    id_stall   = 1'b0;
    br_target  = '0;
    jmp_target = '0;
    rst        = 1'b0;
    @(posedge clk);
    #1;
    if (chk) begin
      check("rst_req",   imem_req,  0);
      check("rst_addr",  imem_addr, 0);
      check("rst_valid", if_valid,  0);
      check("rst_inst",  if_inst,   0);
      check("rst_pc",    if_pc,     0);
      check("rst_perf",  perf_wait, 0);
    end
    rst = 1'b1;
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // ---- 1: back-to-back fetch from PC=0 ----
    do_reset(13'h0000, 0, 1'b1);
    check("t1_pcnext0", PC_next, 13'h0001);
    step();
    check("t1_req1",   imem_req,  1);
    check("t1_addr0",  imem_addr, 13'h0000);
    check("t1_valid0", if_valid,  0);
    step();
    check("t1_addr1",  imem_addr, 13'h0001);
    check("t1_valid1", if_valid,  1);
    check("t1_ifpc0",  if_pc,     13'h0000);
    check("t1_inst0",  if_inst,   mem_word(13'h0000));
    step();
    check("t1_addr2",  imem_addr, 13'h0002);
    check("t1_ifpc1",  if_pc,     13'h0001);

    // ---- 2: 3-cycle latency at addr 5 ----
    do_reset(13'h0005, 2, 1'b0);
    check("t2_launch_next", PC_next, 13'h0006);
    step();
    check("t2_req_c1",  imem_req,  1);
    check("t2_addr_c1", imem_addr, 13'h0005);
    check("t2_next_c1", PC_next,   13'h0006);
    step();
    check("t2_req_c2",  imem_req,  1);
    check("t2_addr_c2", imem_addr, 13'h0005);
    check("t2_next_c2", PC_next,   13'h0006);
    step();
    check("t2_ack_c3",  imem_ack,  1);
    check("t2_addr_c3", imem_addr, 13'h0005);
    check("t2_next_c3", PC_next,   13'h0007);
    step();
    check("t2_valid",   if_valid,  1);
    check("t2_ifpc",    if_pc,     13'h0005);
    check("t2_addr_c4", imem_addr, 13'h0006);
`ifdef FETCH_PERF_CNT_EN
    check("t2_perf",    perf_wait, 16'd2);
`else
    check("t2_perf",    perf_wait, 16'd0);
`endif

    // ---- 3: decode stall parks result in skid ----
    do_reset(13'h0020, 0, 1'b0);
    step();                               // request 0x20 out
    step();                               // IF/ID=0x20, request 0x21 out
    check("t3_valid",  if_valid,  1);
    check("t3_addr21", imem_addr, 13'h0021);
    id_stall = 1'b1;
    #1;
    check("t3_hold_next", PC_next, 13'h0022);
    step();
    check("t3_req_off", imem_req, 0);
    check("t3_ifpc_hold", if_pc,  13'h0020);
    step();
    step();
    step();
    check("t3_req_off_late", imem_req, 0);
    check("t3_valid_hold",   if_valid, 1);
    check("t3_next_late",    PC_next,  13'h0022);
    id_stall = 1'b0;
    #1;
    check("t3_release_next", PC_next, 13'h0023);
    step();
    check("t3_skid_pc",   if_pc,     13'h0021);
    check("t3_skid_inst", if_inst,   mem_word(13'h0021));
    check("t3_relaunch",  imem_req,  1);
    check("t3_reladdr",   imem_addr, 13'h0022);

    // ---- 4: branch redirect with request outstanding ----
    do_reset(13'h0040, 2, 1'b0);
    step();                               // request 0x40 out, waiting
    check("t4_addr40", imem_addr, 13'h0040);
    br_taken  = 1'b1;
    br_target = 13'h0100;
    #1;
    check("t4_redir_next", PC_next, 13'h0100);
    step();
    br_taken = 1'b0;
    #1;
    check("t4_flush",     if_valid,  0);
    check("t4_req_kept",  imem_req,  1);
    check("t4_addr_kept", imem_addr, 13'h0040);
    check("t4_drop_next", PC_next,   13'h0100);
    step();                               // ack for 0x40 this cycle
    check("t4_ack",        imem_ack, 1);
    check("t4_relaunch_n", PC_next,  13'h0101);
    step();
    check("t4_discard",   if_valid,  0);
    check("t4_new_addr",  imem_addr, 13'h0100);

    // ---- 5: branch over jump priority ----
    do_reset(13'h0050, 0, 1'b0);
    br_taken   = 1'b1;
    br_target  = 13'h0010;
    jmp        = 1'b1;
    jmp_target = 13'h0020;
    #1;
    check("t5_br_prio", PC_next, 13'h0010);
    br_taken = 1'b0;
    #1;
    check("t5_jmp", PC_next, 13'h0020);
    jmp = 1'b0;
    #1;

    // ---- 6: PC wrap, then reset mid-request ----
    do_reset(13'h1FFF, 0, 1'b0);
    check("t6_wrap", PC_next, 13'h0000);
    step();
    check("t6_addr1fff", imem_addr, 13'h1FFF);
    step();
    imem_wait = 50;
    id_stall  = 1'b1;
    #1;
    check("t6_ifpc",   if_pc,     13'h1FFF);
    check("t6_addr0",  imem_addr, 13'h0000);
    step();
    check("t6_valid_pre", if_valid, 1);
    check("t6_req_pre",   imem_req, 1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_req",   imem_req,  0);
    check("t6_rst_valid", if_valid,  0);
    check("t6_rst_perf",  perf_wait, 0);
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_inst_fetch_unit
